// File: rtl/forward_ctrl.sv
// Forwarding / load-use hazard control for a 5-stage pipeline.
// Build option FORWARD_CTRL_FORWARDING_EN enables forwarding selects; without it every hazard stalls.
module forward_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  input  logic [4:0] id_rn,
  input  logic [4:0] id_rm,
  input  logic [4:0] id_rd,
  input  logic       id_reg_write,
  input  logic       id_mem_read,
  input  logic       flush,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel,
  output logic       stall
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } entry_t;

  localparam entry_t BUBBLE = '{valid: 1'b0, rd: 5'd0, reg_write: 1'b0, mem_read: 1'b0};

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;
  localparam logic [1:0] SEL_RET = 2'b11;

  entry_t     ex_q, mem_q, wb_q;
  entry_t     ex_d;
  logic [1:0] fwd_a_q, fwd_b_q;
  logic [1:0] fwd_a_d, fwd_b_d;
  logic [1:0] sel_a, sel_b;
  logic       load_ex;
  logic       rn_ex, rn_mem, rn_wb;
  logic       rm_ex, rm_mem, rm_wb;

  // X31 is the zero register, so it never counts as a produced value.
  function automatic logic hit(input entry_t e, input logic [4:0] s);
    return e.valid & e.reg_write & (e.rd == s) & (s != 5'd31);
  endfunction

  function automatic logic [1:0] nearest(input logic h_ex, input logic h_mem, input logic h_wb);
    if (h_ex)
      return SEL_MEM;
    else if (h_mem)
      return SEL_WB;
    else if (h_wb)
      return SEL_RET;
    else
      return SEL_RF;
  endfunction

  always_comb begin
    rn_ex  = hit(ex_q,  id_rn);
    rn_mem = hit(mem_q, id_rn);
    rn_wb  = hit(wb_q,  id_rn);
    rm_ex  = hit(ex_q,  id_rm);
    rm_mem = hit(mem_q, id_rm);
    rm_wb  = hit(wb_q,  id_rm);
  end

`ifdef FORWARD_CTRL_FORWARDING_EN
  // Only a load in EX is too late to forward; everything else is bypassed.
  always_comb begin
    sel_a = nearest(rn_ex, rn_mem, rn_wb);
    sel_b = nearest(rm_ex, rm_mem, rm_wb);
    stall = id_valid & ~flush & ex_q.mem_read & (rn_ex | rm_ex);
  end
`else
  // No bypass paths: hold the consumer until every producer has retired.
  always_comb begin
    sel_a = SEL_RF;
    sel_b = SEL_RF;
    stall = id_valid & ~flush & (rn_ex | rn_mem | rn_wb | rm_ex | rm_mem | rm_wb);
  end
`endif

  always_comb begin
    load_ex = id_valid & ~stall & ~flush;
    ex_d    = BUBBLE;
    fwd_a_d = SEL_RF;
    fwd_b_d = SEL_RF;
    if (load_ex) begin
      ex_d.valid     = 1'b1;
      ex_d.rd        = id_rd;
      ex_d.reg_write = id_reg_write;
      ex_d.mem_read  = id_mem_read;
      fwd_a_d        = sel_a;
      fwd_b_d        = sel_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q    <= BUBBLE;
      mem_q   <= BUBBLE;
      wb_q    <= BUBBLE;
      fwd_a_q <= SEL_RF;
      fwd_b_q <= SEL_RF;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;

  // Load flags past EX are tracked for completeness but never consulted.
  logic unused_mem_read;
  assign unused_mem_read = mem_q.mem_read ^ wb_q.mem_read;

endmodule

// File: tb/tb_forward_ctrl.sv
// Scoreboard bench for forward_ctrl: driver queues hand-computed expectations, negedge monitor checks them.
// Vector set follows FORWARD_CTRL_FORWARDING_EN.
module tb_forward_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rn, id_rm, id_rd;
  logic       id_reg_write, id_mem_read, flush;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       stall;

  always #5 clk = ~clk;

  forward_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rn        (id_rn),
    .id_rm        (id_rm),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .stall        (stall)
  );

  typedef struct {
    int         idx;
    logic       chk_stall;
    logic       stall;
    logic [1:0] a;
    logic [1:0] b;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   vec_n = 0;

  // Expected selects are those visible during this cycle, i.e. loaded at the previous edge.
  task automatic v(input logic rst, input logic vld, input logic [4:0] rn, input logic [4:0] rm,
                   input logic [4:0] rd, input logic rw, input logic mr, input logic fl,
                   input logic chk_st, input logic est, input logic [1:0] ea, input logic [1:0] eb);
    exp_t e;
    @(posedge clk);
    #1;
    reset        = rst;
    id_valid     = vld;
    id_rn        = rn;
    id_rm        = rm;
    id_rd        = rd;
    id_reg_write = rw;
    id_mem_read  = mr;
    flush        = fl;
    vec_n++;
    e.idx       = vec_n;
    e.chk_stall = chk_st;
    e.stall     = est;
    e.a         = ea;
    e.b         = eb;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (e.chk_stall) begin
          total++;
          if (stall !== e.stall) begin
            bad++;
            $display("FAIL v%0d stall got=%0b exp=%0b", e.idx, stall, e.stall);
          end
        end
        total++;
        if (fwd_a_sel !== e.a) begin
          bad++;
          $display("FAIL v%0d fwd_a_sel got=%b exp=%b", e.idx, fwd_a_sel, e.a);
        end
        total++;
        if (fwd_b_sel !== e.b) begin
          bad++;
          $display("FAIL v%0d fwd_b_sel got=%b exp=%b", e.idx, fwd_b_sel, e.b);
        end
      end
    end
  end

  initial begin : driver
    reset = 1'b1; id_valid = 1'b0; id_rn = '0; id_rm = '0; id_rd = '0;
    id_reg_write = 1'b0; id_mem_read = 1'b0; flush = 1'b0;
    @(posedge clk);
    @(posedge clk);
`ifdef FORWARD_CTRL_FORWARDING_EN
    //  rst vld rn  rm  rd  rw mr fl  chk st  a      b
    v(0, 1,  5,  6,  1, 1, 0, 0, 1, 0, 2'b00, 2'b00); // 1  ADD X1, reset state visible
    v(0, 1,  1,  7,  8, 1, 0, 0, 1, 0, 2'b00, 2'b00); // 2  SUB rn=1
    v(0, 1,  9, 10,  2, 1, 0, 0, 1, 0, 2'b01, 2'b00); // 3  producer X2; SUB got a=01
    v(0, 1, 11, 12, 13, 1, 0, 0, 1, 0, 2'b00, 2'b00); // 4  independent
    v(0, 1, 14,  2, 15, 1, 0, 0, 1, 0, 2'b00, 2'b00); // 5  consumer rm=2
    v(0, 1, 17, 18,  2, 1, 0, 0, 1, 0, 2'b00, 2'b10); // 6  distance 2 -> b=10; new producer X2
    v(0, 1, 19, 20, 21, 1, 0, 0, 1, 0, 2'b00, 2'b00); // 7
    v(0, 1, 22, 23, 24, 1, 0, 0, 1, 0, 2'b00, 2'b00); // 8
    v(0, 1, 25,  2, 26, 1, 0, 0, 1, 0, 2'b00, 2'b00); // 9  consumer rm=2
    v(0, 1, 27, 27,  3, 1, 1, 0, 1, 0, 2'b00, 2'b11); // 10 distance 3 -> b=11; LDUR X3
    v(0, 1,  3, 28, 29, 1, 0, 0, 1, 1, 2'b00, 2'b00); // 11 load-use stall
    v(0, 1,  3, 28, 29, 1, 0, 0, 1, 0, 2'b00, 2'b00); // 12 bubble in EX, re-presented
    v(0, 1,  1,  1, 31, 1, 0, 0, 1, 0, 2'b10, 2'b00); // 13 ADD got a=10; producer X31
    v(0, 1, 31, 31,  5, 1, 0, 0, 1, 0, 2'b00, 2'b00); // 14 consumer X31
    v(0, 1,  6,  7,  4, 1, 0, 0, 1, 0, 2'b00, 2'b00); // 15 X31 gave 00; producer X4
    v(0, 1,  8,  9,  4, 1, 0, 0, 1, 0, 2'b00, 2'b00); // 16 producer X4 again
    v(0, 1,  4,  5, 10, 1, 0, 0, 1, 0, 2'b00, 2'b00); // 17 rn=4 (EX,MEM) rm=5 (WB)
    v(0, 1,  4,  4, 11, 1, 0, 0, 1, 0, 2'b01, 2'b11); // 18 independent selects; rn==rm
    v(0, 1,  0,  0, 12, 1, 1, 0, 1, 0, 2'b10, 2'b10); // 19 both 10; LDUR X12
    v(0, 1, 12,  0, 13, 1, 0, 1, 1, 0, 2'b00, 2'b00); // 20 load-use under flush
    v(0, 1, 11,  0, 14, 0, 0, 0, 1, 0, 2'b00, 2'b00); // 21 flush bubble gave 00
    v(0, 1,  0,  0, 15, 1, 1, 0, 1, 0, 2'b11, 2'b00); // 22 rn=11 from WB; LDUR X15
    v(1, 1,  1, 15, 16, 1, 0, 0, 0, 0, 2'b00, 2'b00); // 23 reset during load-use
    v(0, 1,  1, 15, 16, 1, 0, 0, 1, 0, 2'b00, 2'b00); // 24 stall cancelled, load dropped
    v(0, 0,  0,  0,  0, 0, 0, 0, 1, 0, 2'b00, 2'b00); // 25 rm=15 resolved to 00
    v(0, 0,  0,  0,  0, 0, 0, 0, 1, 0, 2'b00, 2'b00); // 26
`else
    //  rst vld rn  rm  rd  rw mr fl  chk st  a      b
    v(0, 1,  5,  6,  1, 1, 0, 0, 1, 0, 2'b00, 2'b00); // 1  ADD X1
    v(0, 1,  1,  7,  8, 1, 0, 0, 1, 1, 2'b00, 2'b00); // 2  SUB rn=1, ADD in EX
    v(0, 1,  1,  7,  8, 1, 0, 0, 1, 1, 2'b00, 2'b00); // 3  ADD in MEM
    v(0, 1,  1,  7,  8, 1, 0, 0, 1, 1, 2'b00, 2'b00); // 4  ADD in WB
    v(0, 1,  1,  7,  8, 1, 0, 0, 1, 0, 2'b00, 2'b00); // 5  SUB proceeds
    v(0, 1,  0,  0, 31, 1, 0, 0, 1, 0, 2'b00, 2'b00); // 6  producer X31
    v(0, 1, 31, 31,  2, 1, 0, 0, 1, 0, 2'b00, 2'b00); // 7  zero reg never stalls
    v(0, 1,  9,  9,  3, 0, 0, 0, 1, 0, 2'b00, 2'b00); // 8  non-writer of X3
    v(0, 1,  3,  2,  4, 1, 0, 0, 1, 1, 2'b00, 2'b00); // 9  X2 in MEM stalls, X3 does not
    v(0, 1,  3,  2,  4, 1, 0, 1, 1, 0, 2'b00, 2'b00); // 10 flush beats WB match
    v(0, 1,  3,  2,  4, 1, 0, 0, 1, 0, 2'b00, 2'b00); // 11 no writer left
    v(1, 1,  4,  0,  5, 1, 0, 0, 0, 0, 2'b00, 2'b00); // 12 reset during stall
    v(0, 1,  4,  0,  5, 1, 0, 0, 1, 0, 2'b00, 2'b00); // 13 producer dropped
    v(0, 0,  5,  5,  0, 0, 0, 0, 1, 0, 2'b00, 2'b00); // 14 invalid ID never stalls
    v(0, 0,  0,  0,  0, 0, 0, 0, 1, 0, 2'b00, 2'b00); // 15
`endif
    @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/forward_ctrl.md
FORWARD_CTRL -- requirements
Module: forward_ctrl

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 id_valid  input  1  a real instruction is in ID this cycle.
REQ-004 id_rn  input  5  first source register of the ID instruction.
REQ-005 id_rm  input  5  second source register of the ID instruction.
REQ-006 id_rd  input  5  destination register of the ID instruction.
REQ-007 id_reg_write  input  1  ID instruction writes id_rd.
REQ-008 id_mem_read  input  1  ID instruction is a load.
REQ-009 flush  input  1  branch taken; the ID instruction is discarded.
REQ-010 fwd_a_sel  output  2  registered select for the operand-A 4:1 mux in EX.
REQ-011 fwd_b_sel  output  2  registered select for the operand-B 4:1 mux in EX.
REQ-012 stall  output  1  combinational; hold PC and IF/ID this cycle.

Function
REQ-013 Select encoding: 00 = register file, 01 = MEM-stage ALU result, 10 = WB-stage result, 11 = retired-result latch (one cycle after WB).
REQ-014 The block keeps three tracking entries, EX, MEM and WB, each holding {valid, rd, reg_write, mem_read}.
REQ-015 Every edge: WB <= MEM and MEM <= EX, unconditionally; downstream never stalls.
REQ-016 Every edge: EX <= ID fields with valid=1 when id_valid & !stall & !flush; otherwise EX <= bubble (valid=0, reg_write=0, mem_read=0).
REQ-017 A match exists for source s in an entry when: the entry is valid, reg_write=1, entry rd == s, and s != 31 (X31 is the zero register and never matches).
REQ-018 Selects are computed from id_rn/id_rm against the current EX, MEM and WB entries, nearest first: EX match -> 01, else MEM match -> 10, else WB match -> 11, else 00.
REQ-019 On each edge, fwd_a_sel/fwd_b_sel load the computed selects when EX loads a valid instruction; they load 00 when EX loads a bubble.
REQ-020 Load-use: stall = id_valid & !flush & the EX entry is valid with mem_read=1 and matches id_rn or id_rm.
REQ-021 A load-use stall lasts exactly one cycle: the bubble moves the load to MEM, and the re-presented instruction then selects 10.
REQ-022 flush has priority over stall: stall=0 and EX takes a bubble.
REQ-023 When both operands match different entries, each select is resolved independently.
REQ-024 id_rn == id_rm resolves both selects identically.

Reset
REQ-025 While reset is high at an edge: all entries are cleared to bubble, and fwd_a_sel = fwd_b_sel = 00.
REQ-026 stall = 0 in the cycle after reset, since EX is invalid.
REQ-027 Reset asserted mid-stall cancels the stall; the in-flight load is dropped from tracking.

Configuration
REQ-028 Macro FORWARD_CTRL_FORWARDING_EN defined: behaviour is as in REQ-013..REQ-024.
REQ-029 Macro undefined:
- fwd_a_sel and fwd_b_sel are held at 00.
- stall = id_valid & !flush & the ID instruction matches any of EX, MEM or WB (per REQ-017), loads or not.
- The instruction stalls until no producer remains in the pipeline (up to 3 cycles).

Verification
REQ-030 Back-to-back ALU ops: ADD X1 (rd=1, reg_write) then SUB reading rn=1 -> SUB enters EX with fwd_a_sel=01 and stall never asserted.
REQ-031 Distance 2 and distance 3: a producer of rd=2 followed by one independent instruction, then a consumer with rm=2 -> fwd_b_sel=10. The same with two independent instructions in between -> fwd_b_sel=11.
REQ-032 Load-use: LDUR X3 then ADD reading rn=3 -> stall=1 for exactly one cycle and EX holds a bubble (both selects 00). The ADD then enters EX with fwd_a_sel=10.
REQ-033 Zero register and priority:
- A producer of rd=31 followed by a consumer with rn=31 -> sel 00.
- Producers of rd=4 in both EX and MEM -> consumer with rn=4 gets sel 01.
REQ-034 flush=1 together with a load-use match -> stall=0, EX takes a bubble, and the next selects are 00.
REQ-035 Reset asserted during a stall cycle -> the next cycle shows stall=0, both selects 00, and all entries invalid. Without FORWARD_CTRL_FORWARDING_EN, an ADD X1 then SUB rn=1 sequence -> stall=1 for 3 cycles with selects 00.
